// File: rtl/alu_pipe_seq_if.sv
// Operand/result handshake bundle for alu_pipe_seq.
// The slave side is the ALU; the master side is the decode stage plus the writeback consumer.
interface alu_pipe_seq_if #(parameter int N = 64);
  logic         InValid;
  logic         InReady;
  logic [N-1:0] BusA;
  logic [N-1:0] BusB;
  logic [3:0]   ALUCtrl;
  logic         OutValid;
  logic         OutReady;
  logic [N-1:0] BusW;
  logic         Zero;
  logic         Negative;
  logic         Carry;
  logic         Overflow;

  modport slave (
    input  InValid, BusA, BusB, ALUCtrl, OutReady,
    output InReady, OutValid, BusW, Zero, Negative, Carry, Overflow
  );

  modport master (
    output InValid, BusA, BusB, ALUCtrl, OutReady,
    input  InReady, OutValid, BusW, Zero, Negative, Carry, Overflow
  );
endinterface

// File: rtl/alu_pipe_seq.sv
// Execute-stage ALU with valid/ready handshakes, registered NZCV result and an
// iterative shift-add multiplier (single-cycle ops complete at the accept edge).
module alu_pipe_seq #(
  parameter int N = 64
) (
  input logic          CLK,
  input logic          Reset_L,
  alu_pipe_seq_if.slave bus
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_PSB = 4'b0111, OP_MUL = 4'b1000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, stateNxt;

  logic [N-1:0]  acc, mcand, mplier, res, busW;
  logic [CW-1:0] cnt;
  logic [N:0]    sum, diff;
  logic          resC, resV, zero, neg, carry, ovf;
  logic          accept, isMul;

  assign bus.InReady  = (state == IDLE) || (state == DONE && bus.OutReady);
  assign bus.OutValid = (state == DONE);
  assign bus.BusW     = busW;
  assign bus.Zero     = zero;
  assign bus.Negative = neg;
  assign bus.Carry    = carry;
  assign bus.Overflow = ovf;

  assign accept = bus.InValid && bus.InReady;
  assign isMul  = (bus.ALUCtrl == OP_MUL);
  assign sum    = {1'b0, bus.BusA} + {1'b0, bus.BusB};
  assign diff   = {1'b0, bus.BusA} - {1'b0, bus.BusB};

  // Single-cycle result path; MUL is handled by the iterative datapath below.
  always_comb begin
    res  = '0;
    resC = 1'b0;
    resV = 1'b0;
    case (bus.ALUCtrl)
      OP_AND: res = bus.BusA & bus.BusB;
      OP_OR:  res = bus.BusA | bus.BusB;
      OP_ADD: begin
        res  = sum[N-1:0];
        resC = sum[N];
        resV = (bus.BusA[N-1] == bus.BusB[N-1]) && (sum[N-1] != bus.BusA[N-1]);
      end
      OP_SUB: begin
        res  = diff[N-1:0];
        resC = ~diff[N];
        resV = (bus.BusA[N-1] != bus.BusB[N-1]) && (diff[N-1] != bus.BusA[N-1]);
      end
      OP_PSB: res = bus.BusB;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) state <= IDLE;
    else          state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: if (accept) stateNxt = isMul ? BUSY : DONE;
      BUSY: if (cnt == '0) stateNxt = DONE;
      DONE: if (bus.OutReady) stateNxt = bus.InValid ? (isMul ? BUSY : DONE) : IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Counter hits zero after N iterations; the following BUSY edge publishes the product.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      busW   <= '0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (isMul) begin
        acc    <= '0;
        mcand  <= bus.BusA;
        mplier <= bus.BusB;
        cnt    <= CW'(N);
      end else begin
        busW  <= res;
        zero  <= (res == '0);
        neg   <= res[N-1];
        carry <= resC;
        ovf   <= resV;
      end
    end else if (state == BUSY) begin
      if (cnt != '0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end else begin
        busW  <= acc;
        zero  <= (acc == '0);
        neg   <= acc[N-1];
        carry <= 1'b0;
        ovf   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe_seq.sv
// Self-checking bench: N=64 vector table and back-to-back stream, N=8 corner sequences
// and randomized ops against an arithmetic reference model.
module tb_alu_pipe_seq;
  logic CLK = 1'b0;
  logic Reset_L = 1'b0;
  always #5 CLK = ~CLK;

  alu_pipe_seq_if #(.N(8))  b8();
  alu_pipe_seq_if #(.N(64)) b64();

  alu_pipe_seq #(.N(8))  u8  (.CLK(CLK), .Reset_L(Reset_L), .bus(b8));
  alu_pipe_seq #(.N(64)) u64 (.CLK(CLK), .Reset_L(Reset_L), .bus(b64));

  int nVec = 0;
  int nMis = 0;

  typedef struct {
    logic [63:0] a, b;
    logic [3:0]  op;
    logic [63:0] w;
    logic [3:0]  zncv;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: plain integer arithmetic on 8-bit operands, returns {w, Z, N, C, V}.
  function automatic logic [11:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int ua = a, ub = b, sa = $signed(a), sb = $signed(b), r = 0, sr = 0;
    logic c = 1'b0, v = 1'b0;
    logic [7:0] w;
    case (op)
      4'b0000: r = ua & ub;
      4'b0001: r = ua | ub;
      4'b0010: begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127 || sr < -128); end
      4'b0110: begin r = ua - ub; c = (ua >= ub); sr = sa - sb; v = (sr > 127 || sr < -128); end
      4'b0111: r = ub;
      4'b1000: r = ua * ub;
      default: r = 0;
    endcase
    w = r[7:0];
    return {w, (w == 8'd0), w[7], c, v};
  endfunction

  // Issue one op on the 8-bit unit, optionally stall the consumer, then retire it.
  task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                     input int stall, input string nm);
    logic [11:0] e;
    int lat = 0, bad = 0;
    e = ref8(a, b, op);
    b8.BusA = a; b8.BusB = b; b8.ALUCtrl = op; b8.InValid = 1'b1; b8.OutReady = 1'b0;
    tick();
    b8.InValid = 1'b0; b8.BusA = ~a; b8.BusB = ~b; b8.ALUCtrl = 4'b0010;
    while (!b8.OutValid && lat < 20) begin
      if (b8.InReady) bad++;
      tick();
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), (op == 4'b1000) ? 64'd9 : 64'd0);
    chk({nm, " busy InReady"}, 64'(bad), 64'd0);
    chk({nm, " BusW"}, 64'(b8.BusW), 64'(e[11:4]));
    chk({nm, " ZNCV"}, 64'({b8.Zero, b8.Negative, b8.Carry, b8.Overflow}), 64'(e[3:0]));
    for (int i = 0; i < stall; i++) begin
      b8.BusA = 8'($urandom); b8.BusB = 8'($urandom);
      tick();
      chk({nm, " stall"}, 64'({b8.OutValid, b8.InReady, b8.BusW}), 64'({2'b10, e[11:4]}));
    end
    b8.OutReady = 1'b1;
    tick();
    b8.OutReady = 1'b0;
    chk({nm, " retire"}, 64'({b8.OutValid, b8.InReady, b8.BusW}), 64'({2'b01, e[11:4]}));
  endtask

  task automatic run64(input vec_t t, input string nm);
    int lat = 0;
    b64.BusA = t.a; b64.BusB = t.b; b64.ALUCtrl = t.op; b64.InValid = 1'b1; b64.OutReady = 1'b0;
    tick();
    b64.InValid = 1'b0; b64.BusA = '1; b64.BusB = '1;
    while (!b64.OutValid && lat < 80) begin tick(); lat++; end
    chk({nm, " latency"}, 64'(lat), (t.op == 4'b1000) ? 64'd65 : 64'd0);
    chk({nm, " BusW"}, b64.BusW, t.w);
    chk({nm, " ZNCV"}, 64'({b64.Zero, b64.Negative, b64.Carry, b64.Overflow}), 64'(t.zncv));
    b64.OutReady = 1'b1;
    tick();
    b64.OutReady = 1'b0;
    chk({nm, " idle"}, 64'({b64.OutValid, b64.InReady}), 64'b01);
  endtask

  initial begin
    logic [3:0] ops[7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1111};
    int seen;
    tbl[0] = '{64'd5, 64'd7, 4'b0010, 64'd12, 4'b0000};
    tbl[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'h8000_0000_0000_0000, 4'b0101};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd0, 4'b1010};
    tbl[3] = '{64'd5, 64'd7, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100};
    tbl[4] = '{64'd3, 64'd3, 4'b0110, 64'd0, 4'b1010};
    tbl[5] = '{64'h0000_0001_0000_0001, 64'd3, 4'b1000, 64'h0000_0003_0000_0003, 4'b0000};
    tbl[6] = '{64'hABCD, 64'h1234, 4'b0011, 64'd0, 4'b1000};
    tbl[7] = '{64'hF0F0, 64'hFF00, 4'b0000, 64'hF000, 4'b0000};

    b8.InValid = 0;  b8.OutReady = 0;  b8.BusA = 0;  b8.BusB = 0;  b8.ALUCtrl = 0;
    b64.InValid = 0; b64.OutReady = 0; b64.BusA = 0; b64.BusB = 0; b64.ALUCtrl = 0;
    #1;
    chk("reset state", 64'({b8.OutValid, b8.InReady, b8.BusW, b8.Zero, b8.Negative, b8.Carry, b8.Overflow}),
        64'({2'b01, 8'd0, 4'd0}));
    @(negedge CLK) Reset_L = 1'b1;
    #1;

    foreach (tbl[i]) run64(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back single-cycle ops with the consumer always ready.
    b64.OutReady = 1'b1; b64.InValid = 1'b1;
    b64.BusA = 64'hF0F0; b64.BusB = 64'hFF00; b64.ALUCtrl = 4'b0000;
    tick();
    chk("b2b AND", {b64.OutValid, b64.BusW[62:0]}, {1'b1, 63'hF000});
    b64.BusA = 64'h00F0; b64.BusB = 64'h0F00; b64.ALUCtrl = 4'b0001;
    tick();
    chk("b2b OR", {b64.OutValid, b64.BusW[62:0]}, {1'b1, 63'h0FF0});
    b64.BusA = 64'hDEAD; b64.BusB = 64'h1234; b64.ALUCtrl = 4'b0111;
    tick();
    chk("b2b PassB", {b64.OutValid, b64.BusW[62:0]}, {1'b1, 63'h1234});
    b64.InValid = 1'b0;
    tick();
    b64.OutReady = 1'b0;
    chk("b2b drain", 64'({b64.OutValid, b64.InReady}), 64'b01);

    // Test-plan sequences on the 8-bit unit.
    do8(8'h80, 8'h01, 4'b0110, 0, "sub ovf");
    chk("sub ovf const", 64'({b8.BusW, b8.Negative, b8.Carry, b8.Overflow}), 64'({8'h7F, 3'b011}));
    do8(8'd3, 8'd3, 4'b0110, 0, "sub eq");
    chk("sub eq const", 64'({b8.BusW, b8.Zero, b8.Carry}), 64'({8'h00, 2'b11}));
    do8(8'd0, 8'd1, 4'b0110, 0, "sub borrow");
    chk("sub borrow const", 64'({b8.BusW, b8.Negative, b8.Carry}), 64'({8'hFF, 2'b10}));
    do8(8'd13, 8'd11, 4'b1000, 0, "mul 13x11");
    chk("mul const", 64'(b8.BusW), 64'h8F);
    do8(8'h10, 8'h10, 4'b1000, 0, "mul wrap");
    chk("mul wrap Z", 64'({b8.BusW, b8.Zero}), 64'({8'h00, 1'b1}));

    // Output stall: pending request must wait for OutReady, then retire+accept same edge.
    b8.BusA = 8'h10; b8.BusB = 8'h22; b8.ALUCtrl = 4'b0010; b8.InValid = 1'b1; b8.OutReady = 1'b0;
    tick();
    b8.ALUCtrl = 4'b0110;
    chk("stall first", 64'({b8.OutValid, b8.BusW}), 64'({1'b1, 8'h32}));
    for (int i = 0; i < 5; i++) begin
      b8.BusA = 8'($urandom); b8.BusB = 8'($urandom);
      tick();
      chk("stall hold", 64'({b8.OutValid, b8.InReady, b8.BusW, b8.Zero, b8.Negative, b8.Carry, b8.Overflow}),
          64'({2'b10, 8'h32, 4'b0000}));
    end
    b8.BusA = 8'd9; b8.BusB = 8'd4; b8.OutReady = 1'b1;
    tick();
    b8.InValid = 1'b0; b8.OutReady = 1'b0;
    chk("stall accept", 64'({b8.OutValid, b8.BusW, b8.Carry}), 64'({1'b1, 8'h05, 1'b1}));
    b8.OutReady = 1'b1;
    tick();
    b8.OutReady = 1'b0;
    chk("stall retire", 64'(b8.OutValid), 64'd0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 150; i++)
      do8(8'($urandom), 8'($urandom), ops[$urandom_range(0, 6)], $urandom_range(0, 3), $sformatf("rnd%0d", i));

    // Asynchronous reset three cycles into a multiply.
    b8.BusA = 8'd13; b8.BusB = 8'd11; b8.ALUCtrl = 4'b1000; b8.InValid = 1'b1;
    tick();
    b8.InValid = 1'b0;
    tick(); tick(); tick();
    #2 Reset_L = 1'b0;
    #1;
    chk("async reset", 64'({b8.OutValid, b8.InReady, b8.BusW, b8.Zero, b8.Negative, b8.Carry, b8.Overflow}),
        64'({2'b01, 8'd0, 4'd0}));
    @(negedge CLK) Reset_L = 1'b1;
    #1;
    do8(8'd1, 8'd1, 4'b0010, 0, "post-reset add");
    chk("post-reset add const", 64'(b8.BusW), 64'd2);
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (b8.OutValid) seen++; end
    chk("no stale mul", 64'(seen), 64'd0);
    do8(8'hA5, 8'h3C, 4'b1111, 0, "undef op");
    chk("undef const", 64'({b8.BusW, b8.Zero, b8.Carry, b8.Overflow}), 64'({8'h00, 3'b100}));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
